fp_addsub_seq: RTL
==================

FP_ADDSUB_SEQ -- requirements
Module: fp_addsub_seq

Interface
REQ-001 SHALL have port: clk  input  1  clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; clock clk.
REQ-003 SHALL have port: start  input  1  request; accepted only in IDLE.
REQ-004 SHALL have port: op  input  1  0=a+b, 1=a-b (see REQ-027).
REQ-005 SHALL have port: a  input  32  IEEE-754 single operand A.
REQ-006 SHALL have port: b  input  32  IEEE-754 single operand B.
REQ-007 SHALL have port: result  output  32  packed sum/difference, held until next accepted start.
REQ-008 SHALL have port: busy  output  1  high whenever state != IDLE.
REQ-009 SHALL have port: done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port: ovf  output  1  overflow flag, valid with done, held with result.
REQ-011 SHALL have port: inv  output  1  invalid-operation flag, valid with done, held with result.

Function
REQ-012 SHALL implement FSM IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> DONE -> IDLE, one cycle per state except IDLE.
REQ-013 SHALL register a, b, op on the edge where start=1 in IDLE; later input changes have no effect on the operation in flight.
REQ-014 SHALL ignore start while busy=1 (no queueing, no restart).
REQ-015 SHALL assert done only in DONE: fixed latency, done high in the 5th cycle after the accepting edge; done and start may not overlap an accept (DONE -> IDLE first).
REQ-016 SHALL update result, ovf, inv only on entry to DONE; previous values held otherwise.
REQ-017 UNPACK: exponent field 0 treated as zero (denormals flushed, sign kept); hidden 1 prepended otherwise.
REQ-018 ALIGN: swap so larger magnitude is first; shift smaller 24-bit significand right by exponent difference with guard, round, sticky bits; difference >= 27 leaves only sticky.
REQ-019 ADD: effective subtract when signs differ after op applied; 28-bit add/subtract, result sign = sign of larger magnitude.
REQ-020 NORM: carry-out shifts right 1 (exp+1); otherwise left shift by leading-zero count (single cycle); round toward zero (truncate G/R/S).
REQ-021 Exact-zero result (cancellation, or both operands zero with differing effective signs) SHALL be +0 (32'h00000000); both zero, same sign -> zero of that sign.
REQ-022 Result exponent <= 0 after normalization SHALL flush to signed zero, ovf=0.
REQ-023 Result exponent >= 255 SHALL saturate to signed max finite (7F7FFFFF / FF7FFFFF), ovf=1.
REQ-024 Any NaN input, or inf minus inf (effective), SHALL give 32'h7FC00000, inv=1; inf with finite or same-sign inf SHALL give that inf, inv=0, ovf=0.

Reset
REQ-025 reset SHALL force state=IDLE, result=32'h0, done=0, busy=0, ovf=0, inv=0, immediately and asynchronously.
REQ-026 reset asserted mid-operation SHALL abort it; no done pulse for the aborted operation after release.

Configuration
REQ-027 Macro FPADD_SUB_EN: defined -> op=1 inverts sign of captured b before ALIGN; undefined -> op port retained but ignored, always a+b.

Verification
REQ-028 a=3F800000, b=3F800000, op=0, start 1 cycle -> busy 5 cycles, done in 5th, result=40000000, ovf=0, inv=0.
REQ-029 FPADD_SUB_EN defined: a=3FC00000, b=3FC00000, op=1 -> result=00000000; undefined: b=BFC00000, op=1 -> result=00000000.
REQ-030 a=7F800000, b=FF800000, op=0 -> result=7FC00000, inv=1; a=7F7FFFFF, b=7F7FFFFF -> result=7F7FFFFF, ovf=1.
REQ-031 a=3F800000, b=33800000 (2^-24), op=0 -> result=3F800000 (truncated); a=3F800000, b=B3800000 -> result=3F7FFFFF.
REQ-032 start pulsed again 2 cycles after accept with different a/b -> ignored, single done, first result; reset at ALIGN -> all outputs 0, no done, next start completes normally.

Source files
------------

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 single add/subtract: truncating rounding, denormals flushed to zero.
// Optional macro FPADD_SUB_EN: when defined, op=1 computes a-b; otherwise op is ignored (a+b).
module fp_addsub_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic        inv
);
  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, DONE} state_t;
  state_t state, state_nx;

  logic [31:0] a_r, b_r;
  logic        op_r;
  logic        u_sa, u_sb, u_spec, u_inv;
  logic [7:0]  u_ea, u_eb;
  logic [23:0] u_ma, u_mb;
  logic [31:0] u_res;
  logic [26:0] g_big, g_sml;
  logic [7:0]  g_e;
  logic        g_s, g_sub, g_zs;
  logic [27:0] s_sum;
  logic [7:0]  s_e;
  logic        s_s, s_zs;

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = UNPACK;
      UNPACK:  state_nx = ALIGN;
      ALIGN:   state_nx = ADD;
      ADD:     state_nx = NORM;
      NORM:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  logic sb_eff;
`ifdef FPADD_SUB_EN
  assign sb_eff = b_r[31] ^ op_r;
`else
  logic unused_op;
  assign unused_op = op_r;
  assign sb_eff    = b_r[31];
`endif

  // Specials bypass the datapath and are carried alongside it until NORM.
  logic        nan_a, nan_b, inf_a, inf_b, spec_nx, spec_inv;
  logic [31:0] spec_res;
  always_comb begin
    nan_a    = (&a_r[30:23]) && (|a_r[22:0]);
    nan_b    = (&b_r[30:23]) && (|b_r[22:0]);
    inf_a    = (&a_r[30:23]) && !(|a_r[22:0]);
    inf_b    = (&b_r[30:23]) && !(|b_r[22:0]);
    spec_nx  = 1'b0;
    spec_inv = 1'b0;
    spec_res = '0;
    if (nan_a || nan_b || (inf_a && inf_b && (a_r[31] != sb_eff))) begin
      spec_nx = 1'b1; spec_inv = 1'b1; spec_res = 32'h7FC00000;
    end else if (inf_a) begin
      spec_nx = 1'b1; spec_res = {a_r[31], 8'hFF, 23'h0};
    end else if (inf_b) begin
      spec_nx = 1'b1; spec_res = {sb_eff, 8'hFF, 23'h0};
    end
  end

  logic        a_big;
  logic [7:0]  e_b, e_s, d;
  logic [23:0] m_b, m_s;
  logic [53:0] wide;
  logic [26:0] sml_sh;
  always_comb begin
    a_big = {u_ea, u_ma} >= {u_eb, u_mb};
    e_b   = a_big ? u_ea : u_eb;
    e_s   = a_big ? u_eb : u_ea;
    m_b   = a_big ? u_ma : u_mb;
    m_s   = a_big ? u_mb : u_ma;
    d     = e_b - e_s;
    // Lower 27 bits of the wide shift collect everything that falls past the sticky position.
    wide  = {m_s, 30'b0} >> d;
    if (d < 8'd27) sml_sh = wide[53:27] | {26'b0, |wide[26:0]};
    else           sml_sh = {26'b0, |m_s};
  end

  logic [27:0] sum_nx;
  always_comb
    sum_nx = g_sub ? ({1'b0, g_big} - {1'b0, g_sml}) : ({1'b0, g_big} + {1'b0, g_sml});

  logic [4:0]  lz;
  logic [26:0] norm;
  logic [9:0]  exp_n;
  logic [22:0] frac;
  logic [31:0] res_nx;
  logic        ovf_nx, inv_nx;
  logic [3:0]  unused_norm;
  always_comb begin
    lz = '0;
    for (int i = 0; i < 27; i++) if (s_sum[i]) lz = 5'(26 - i);
    norm = s_sum[26:0] << lz;
    if (s_sum[27]) begin
      exp_n = {2'b0, s_e} + 10'd1;
      frac  = s_sum[26:4];
    end else begin
      exp_n = {2'b0, s_e} - {5'b0, lz};
      frac  = norm[25:3];
    end
    res_nx = {s_s, exp_n[7:0], frac};
    ovf_nx = 1'b0;
    inv_nx = 1'b0;
    if (u_spec) begin
      res_nx = u_res; inv_nx = u_inv;
    end else if (s_sum == '0) begin
      res_nx = {s_zs, 31'b0};
    end else if (exp_n[9] || exp_n == '0) begin
      res_nx = {s_s, 31'b0};
    end else if (exp_n >= 10'd255) begin
      res_nx = {s_s, 31'h7F7FFFFF}; ovf_nx = 1'b1;
    end
  end
  assign unused_norm = {norm[26], norm[2:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r <= '0; b_r <= '0; op_r <= 1'b0;
      u_sa <= 1'b0; u_sb <= 1'b0; u_spec <= 1'b0; u_inv <= 1'b0;
      u_ea <= '0; u_eb <= '0; u_ma <= '0; u_mb <= '0; u_res <= '0;
      g_big <= '0; g_sml <= '0; g_e <= '0; g_s <= 1'b0; g_sub <= 1'b0; g_zs <= 1'b0;
      s_sum <= '0; s_e <= '0; s_s <= 1'b0; s_zs <= 1'b0;
      result <= '0; ovf <= 1'b0; inv <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_r <= a; b_r <= b; op_r <= op;
        end
        UNPACK: begin
          u_sa   <= a_r[31];
          u_sb   <= sb_eff;
          u_ea   <= a_r[30:23];
          u_eb   <= b_r[30:23];
          u_ma   <= (a_r[30:23] == '0) ? 24'd0 : {1'b1, a_r[22:0]};
          u_mb   <= (b_r[30:23] == '0) ? 24'd0 : {1'b1, b_r[22:0]};
          u_spec <= spec_nx;
          u_inv  <= spec_inv;
          u_res  <= spec_res;
        end
        ALIGN: begin
          g_big <= {m_b, 3'b0};
          g_sml <= sml_sh;
          g_e   <= e_b;
          g_s   <= a_big ? u_sa : u_sb;
          g_sub <= u_sa ^ u_sb;
          g_zs  <= u_sa & u_sb;
        end
        ADD: begin
          s_sum <= sum_nx; s_e <= g_e; s_s <= g_s; s_zs <= g_zs;
        end
        NORM: begin
          result <= res_nx; ovf <= ovf_nx; inv <= inv_nx;
        end
        default: ;
      endcase
    end
  end
endmodule
